// File: rtl/mem_port_arbiter_pkg.sv
// Shared types, sizes and helpers for the four-requester memory port arbiter.
`default_nettype none

package mem_port_arbiter_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

   // Lowest set bit wins; callers only pass one-hot vectors.
   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] onehot);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int n = NUM_REQ - 1; n >= 0; n--) begin
         if (onehot[n]) begin
            idx = SEL_W'(n);
         end
      end
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, modulo 4.
`default_nettype none

module rr_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               valid,
   output logic [SEL_W-1:0]   idx
);

   logic [SEL_W-1:0] cand [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
      assign cand[k] = ptr + SEL_W'(k);
   end

   // Scan from the farthest offset down so the nearest candidate is assigned last.
   always_comb begin
      valid = 1'b0;
      idx   = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[cand[k]]) begin
            valid = 1'b1;
            idx   = cand[k];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting one shared memory port to four requesters;
// the grant is held until mem_ack_i or a BUSY-cycle timeout releases it.
`default_nettype none

module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               mem_ack_i,
   output logic [SEL_W-1:0]   sel_o,
   output logic [NUM_REQ-1:0] grant_o,
   output logic               mem_req_o,
   output logic [NUM_REQ-1:0] done_o,
   output logic               timeout_o
);

   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT != 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t             state, state_nxt;
   logic [SEL_W-1:0]   ptr, ptr_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [SEL_W-1:0]   sel_nxt;
   logic [NUM_REQ-1:0] grant_nxt;
   logic               mem_req_nxt;
   logic [NUM_REQ-1:0] done_nxt;
   logic               timeout_nxt;

   logic               pick_valid;
   logic [SEL_W-1:0]   pick_idx;

   rr_pick u_rr_pick (
      .req   (req_i),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         sel_o     <= '0;
         grant_o   <= '0;
         mem_req_o <= 1'b0;
         done_o    <= '0;
         timeout_o <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         cnt       <= cnt_nxt;
         sel_o     <= sel_nxt;
         grant_o   <= grant_nxt;
         mem_req_o <= mem_req_nxt;
         done_o    <= done_nxt;
         timeout_o <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      cnt_nxt     = cnt;
      sel_nxt     = sel_o;
      grant_nxt   = grant_o;
      mem_req_nxt = mem_req_o;
      done_nxt    = '0;
      timeout_nxt = 1'b0;

      unique case (state)
         IDLE: begin
            // sel_o deliberately keeps its last value so the shared mux stays stable.
            if (pick_valid) begin
               sel_nxt     = pick_idx;
               grant_nxt   = idx_to_onehot(pick_idx);
               mem_req_nxt = 1'b1;
               cnt_nxt     = '0;
               state_nxt   = BUSY;
            end
         end

         BUSY: begin
            // Ack takes priority over a timeout landing on the same edge.
            if (mem_ack_i) begin
               done_nxt    = grant_o;
               grant_nxt   = '0;
               mem_req_nxt = 1'b0;
               ptr_nxt     = sel_o + SEL_W'(1);
               state_nxt   = IDLE;
            end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
               timeout_nxt = 1'b1;
               grant_nxt   = '0;
               mem_req_nxt = 1'b0;
               ptr_nxt     = sel_o + SEL_W'(1);
               state_nxt   = IDLE;
            end else if (cnt != CNT_MAX) begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Directed, self-checking bench for mem_port_arbiter with TIMEOUT=4.
`default_nettype none

module tb_mem_port_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       ack;
   logic [1:0] sel;
   logic [3:0] grant;
   logic       mem_req;
   logic [3:0] done;
   logic       tmo;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter #(.TIMEOUT(4)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req),
      .mem_ack_i (ack),
      .sel_o     (sel),
      .grant_o   (grant),
      .mem_req_o (mem_req),
      .done_o    (done),
      .timeout_o (tmo)
   );

   always #5 clk = ~clk;

   // Advance one cycle; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 4'b0000;
      ack = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({sel, grant, mem_req, done, tmo} !== 12'b0) begin
         errors++;
         $display("FAIL reset_outputs: got sel=%b grant=%b mreq=%b done=%b tmo=%b want all 0",
                  sel, grant, mem_req, done, tmo);
      end
      checks++;
      if (dut.ptr !== 2'd0) begin
         errors++;
         $display("FAIL reset_ptr: got %0d want 0", dut.ptr);
      end
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0001;
      for (int c = 1; c <= 3; c++) begin
         tick();
         checks++;
         if ({grant, sel, mem_req} !== {4'b0001, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_hold c%0d: got grant=%b sel=%0d mreq=%b want 0001/0/1",
                     c, grant, sel, mem_req);
         end
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      req = 4'b0000;
      checks++;
      if ({done, grant, mem_req, tmo, sel} !== {4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL single_done: got done=%b grant=%b mreq=%b tmo=%b sel=%0d want 0001/0000/0/0/0",
                  done, grant, mem_req, tmo, sel);
      end
      checks++;
      if (dut.ptr !== 2'd1) begin
         errors++;
         $display("FAIL single_ptr: got %0d want 1", dut.ptr);
      end
      tick();
      checks++;
      if ({done, grant} !== 8'b0) begin
         errors++;
         $display("FAIL single_idle: got done=%b grant=%b want 0000/0000", done, grant);
      end
   endtask

   task automatic test_contention();
      logic [3:0] exp_g [5];
      logic [1:0] exp_s [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({grant, sel, mem_req} !== {exp_g[i], exp_s[i], 1'b1}) begin
            errors++;
            $display("FAIL contention_grant #%0d: got grant=%b sel=%0d mreq=%b want %b/%0d/1",
                     i, grant, sel, mem_req, exp_g[i], exp_s[i]);
         end
         ack = 1'b1;
         tick();
         ack = 1'b0;
         if (i == 4) req = 4'b0000;
         checks++;
         if ({grant, mem_req, done} !== {4'b0000, 1'b0, exp_g[i]}) begin
            errors++;
            $display("FAIL contention_gap #%0d: got grant=%b mreq=%b done=%b want 0000/0/%b",
                     i, grant, mem_req, done, exp_g[i]);
         end
      end
      tick();
   endtask

   task automatic test_ptr_skip();
      logic [1:0] exp_s [3];
      exp_s = '{2'd3, 2'd0, 2'd1};
      do_reset();
      req = 4'b0010;
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      req = 4'b1011;
      checks++;
      if (dut.ptr !== 2'd2) begin
         errors++;
         $display("FAIL skip_ptr: got %0d want 2", dut.ptr);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({sel, grant} !== {exp_s[i], 4'b0001 << exp_s[i]}) begin
            errors++;
            $display("FAIL skip_grant #%0d: got sel=%0d grant=%b want sel=%0d",
                     i, sel, grant, exp_s[i]);
         end
         ack = 1'b1;
         tick();
         ack = 1'b0;
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      req = 4'b0100;
      tick();
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if ({grant, sel, tmo, done} !== {4'b0100, 2'd2, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL timeout_hold c%0d: got grant=%b sel=%0d tmo=%b done=%b want 0100/2/0/0000",
                     c, grant, sel, tmo, done);
         end
         tick();
      end
      req = 4'b0000;
      checks++;
      if ({tmo, done, grant, mem_req} !== {1'b1, 4'b0000, 4'b0000, 1'b0}) begin
         errors++;
         $display("FAIL timeout_fire: got tmo=%b done=%b grant=%b mreq=%b want 1/0000/0000/0",
                  tmo, done, grant, mem_req);
      end
      checks++;
      if (dut.ptr !== 2'd3) begin
         errors++;
         $display("FAIL timeout_ptr: got %0d want 3", dut.ptr);
      end
      tick();
      checks++;
      if (tmo !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse_width: got tmo=%b want 0", tmo);
      end
   endtask

   task automatic test_ack_on_timeout();
      do_reset();
      req = 4'b0100;
      tick();
      tick();
      tick();
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      req = 4'b0000;
      checks++;
      if ({done, tmo} !== {4'b0100, 1'b0}) begin
         errors++;
         $display("FAIL ack_vs_timeout: got done=%b tmo=%b want 0100/0", done, tmo);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b0100;
      tick();
      checks++;
      if (sel !== 2'd2) begin
         errors++;
         $display("FAIL midreset_pre: got sel=%0d want 2", sel);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b0101;
      checks++;
      if ({sel, grant, mem_req, done, tmo} !== 12'b0 || dut.ptr !== 2'd0) begin
         errors++;
         $display("FAIL midreset_clear: got sel=%0d grant=%b mreq=%b done=%b tmo=%b ptr=%0d want all 0",
                  sel, grant, mem_req, done, tmo, dut.ptr);
      end
      tick();
      checks++;
      if ({grant, sel} !== {4'b0001, 2'd0}) begin
         errors++;
         $display("FAIL midreset_regrant: got grant=%b sel=%0d want 0001/0", grant, sel);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      req = 4'b0000;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      ack = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_ptr_skip();
      test_timeout();
      test_ack_on_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
